// File: rtl/candy_dispense_ctrl.sv
// Dispense sequencer: synchronised request edge -> spin-up -> stepped units with settle gaps -> done/err.
// One DC agitator per channel plus a shared stepper; every output comes straight from a flop.
module candy_dispense_ctrl #(
  parameter int   NUM_CH         = 3,
  parameter int   SEL_W          = 3,
  parameter int   AMT_W          = 2,
  parameter int   STEP_DIV_SLOW  = 6000,
  parameter int   STEP_DIV_MED   = 3000,
  parameter int   STEP_DIV_FAST  = 1500,
  parameter int   STEPS_PER_UNIT = 200,
  parameter int   SPINUP_CYC     = 120000,
  parameter int   SETTLE_CYC     = 60000,
  parameter logic DIR_FWD        = 1'b1
) (
  input  logic              clk_x1,
  input  logic              rstn,
  input  logic [SEL_W-1:0]  sel,
  input  logic [AMT_W-1:0]  amount,
  input  logic [1:0]        mode,
  input  logic              candyflag,
  input  logic              stop,
  output logic              stepper_step,
  output logic              stepper_dir,
  output logic [NUM_CH-1:0] dcmotor,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int MAX_A   = (SPINUP_CYC > SETTLE_CYC) ? SPINUP_CYC : SETTLE_CYC;
  localparam int MAX_B   = (STEP_DIV_SLOW > STEP_DIV_MED) ? STEP_DIV_SLOW : STEP_DIV_MED;
  localparam int MAX_C   = (MAX_B > STEP_DIV_FAST) ? MAX_B : STEP_DIV_FAST;
  localparam int CNT_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PULSE_W = $clog2(STEPS_PER_UNIT + 1);
  localparam int UNIT_W  = AMT_W + 1;

  localparam logic [CNT_W-1:0]   SPIN_LD   = CNT_W'(SPINUP_CYC - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]   SLOW_LD   = CNT_W'(STEP_DIV_SLOW - 1);
  localparam logic [CNT_W-1:0]   MED_LD    = CNT_W'(STEP_DIV_MED - 1);
  localparam logic [CNT_W-1:0]   FAST_LD   = CNT_W'(STEP_DIV_FAST - 1);
  localparam logic [PULSE_W-1:0] PULSES    = PULSE_W'(STEPS_PER_UNIT);
  localparam logic [SEL_W:0]     NUM_CH_W  = (SEL_W + 1)'(NUM_CH);

  typedef enum logic [2:0] {S_IDLE, S_SPIN_UP, S_STEP, S_SETTLE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, div_ld;
  logic [PULSE_W-1:0]  pulse_q, pulse_d;
  logic [UNIT_W-1:0]   units_q, units_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [1:0]          mode_q, mode_d;
  logic                err_q, err_d, step_q, step_d, dir_q, dir_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [NUM_CH-1:0]   motor_q, motor_d;
  logic                sync1_q, sync2_q, sync3_q, rise;

  // Synchroniser and edge flops reset high so a flag held across reset is not a request.
  always_ff @(posedge clk_x1 or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= candyflag;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;

  always_comb begin
    unique case (mode_q)
      2'b01:   div_ld = MED_LD;
      2'b10:   div_ld = FAST_LD;
      default: div_ld = SLOW_LD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    units_d = units_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    err_d   = err_q;
    step_d  = step_q;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          if ({1'b0, sel} < NUM_CH_W) begin
            sel_d   = sel;
            mode_d  = mode;
            units_d = UNIT_W'(amount) + UNIT_W'(1);
            cnt_d   = SPIN_LD;
            state_d = S_SPIN_UP;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_SPIN_UP: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else begin
          state_d = S_STEP;
          step_d  = 1'b1;
          pulse_d = '0;
          cnt_d   = div_ld;
        end
      end
      S_STEP: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else if (step_q) begin
          // a pulse is counted on its falling edge
          step_d  = 1'b0;
          pulse_d = pulse_q + PULSE_W'(1);
          cnt_d   = div_ld;
        end else if (pulse_q == PULSES) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          step_d  = 1'b1;
          cnt_d   = div_ld;
        end
      end
      S_SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else begin
          units_d = units_q - UNIT_W'(1);
          if (units_q == UNIT_W'(1)) state_d = S_DONE;
          else begin
            state_d = S_STEP;
            step_d  = 1'b1;
            pulse_d = '0;
            cnt_d   = div_ld;
          end
        end
      end
      S_DONE: begin
        if (!sync2_q) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop && (state_q == S_SPIN_UP || state_q == S_STEP || state_q == S_SETTLE)) begin
      state_d = S_DONE;
      err_d   = 1'b1;
      step_d  = 1'b0;
    end
    // outputs are decoded from the next state so they change on the same edge as the state
    busy_d = (state_d == S_SPIN_UP) || (state_d == S_STEP) || (state_d == S_SETTLE);
    done_d = (state_d == S_DONE);
    dir_d  = busy_d ? DIR_FWD : 1'b0;
    for (int i = 0; i < NUM_CH; i++) motor_d[i] = busy_d && (sel_d == SEL_W'(i));
  end

  always_ff @(posedge clk_x1 or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pulse_q <= '0;
      units_q <= '0;
      sel_q   <= '0;
      mode_q  <= '0;
      err_q   <= 1'b0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      motor_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      units_q <= units_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      motor_q <= motor_d;
    end
  end

  assign stepper_step = step_q;
  assign stepper_dir  = dir_q;
  assign dcmotor      = motor_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_candy_dispense_ctrl.sv
// Randomised bench for candy_dispense_ctrl against a timeline model built from the
// request rules (flag edge -> spin-up, stepped units, settle gaps, done handshake).
module tb_candy_dispense_ctrl;
  localparam int NUM_CH = 3, SEL_W = 3, AMT_W = 2;
  localparam int DS = 4, DM = 3, DF = 2, SPU = 2, SPIN = 5, SETTLE = 3;

  logic clk_x1 = 1'b0, rstn = 1'b1, candyflag = 1'b1, stop = 1'b0;
  logic [SEL_W-1:0]  sel = '0;
  logic [AMT_W-1:0]  amount = '0;
  logic [1:0]        mode = '0;
  logic              stepper_step, stepper_dir, busy, done, err;
  logic [NUM_CH-1:0] dcmotor;

  candy_dispense_ctrl #(
    .NUM_CH(NUM_CH), .SEL_W(SEL_W), .AMT_W(AMT_W),
    .STEP_DIV_SLOW(DS), .STEP_DIV_MED(DM), .STEP_DIV_FAST(DF),
    .STEPS_PER_UNIT(SPU), .SPINUP_CYC(SPIN), .SETTLE_CYC(SETTLE), .DIR_FWD(1'b1)
  ) dut (
    .clk_x1(clk_x1), .rstn(rstn), .sel(sel), .amount(amount), .mode(mode),
    .candyflag(candyflag), .stop(stop), .stepper_step(stepper_step),
    .stepper_dir(stepper_dir), .dcmotor(dcmotor), .busy(busy), .done(done), .err(err)
  );

  always #5 clk_x1 = ~clk_x1;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 running (k = cycles since request accepted), 2 done.
  bit f1, f2, f3, m_err;
  int phase, k, len, m_sel, m_mode;
  int busy_cyc, rises;
  bit prev_step;

  function automatic int div_of(input int md);
    if (md == 1) return DM;
    if (md == 2) return DF;
    return DS;
  endfunction

  function automatic int run_len(input int a, input int md);
    return SPIN + (a + 1) * (2 * SPU * div_of(md) + SETTLE);
  endfunction

  function automatic bit exp_step();
    int d, per, r;
    if (phase != 1 || k < SPIN) return 1'b0;
    d = div_of(m_mode);
    per = 2 * SPU * d + SETTLE;
    r = (k - SPIN) % per;
    return (r < 2 * SPU * d) && ((r / d) % 2 == 0);
  endfunction

  task automatic model_reset();
    f1 = 1; f2 = 1; f3 = 1; phase = 0; k = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit rise;
    rise = f2 && !f3;
    case (phase)
      0: if (rise) begin
        if (int'(sel) < NUM_CH) begin
          phase = 1; k = 0; m_sel = int'(sel); m_mode = int'(mode);
          len = run_len(int'(amount), int'(mode));
        end else begin
          phase = 2; m_err = 1;
        end
      end
      1: if (stop) begin
        phase = 2; m_err = 1;
      end else begin
        k++;
        if (k == len) begin phase = 2; m_err = 0; end
      end
      default: if (!f2) begin phase = 0; m_err = 0; end
    endcase
    f3 = f2; f2 = f1; f1 = candyflag;
  endtask

  task automatic check_outputs();
    bit eb;
    eb = (phase == 1);
    chk("busy", 32'(busy), 32'(eb));
    chk("dcmotor", 32'(dcmotor), eb ? (32'd1 << m_sel) : 32'd0);
    chk("dir", 32'(stepper_dir), 32'(eb));
    chk("step", 32'(stepper_step), 32'(exp_step()));
    chk("done", 32'(done), 32'(phase == 2));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk_x1);
    if (rstn) model_step();
    @(negedge clk_x1);
    check_outputs();
    if (busy) busy_cyc++;
    if (stepper_step && !prev_step) rises++;
    prev_step = stepper_step;
  endtask

  task automatic run_req(input int s, input int a, input int md, input int stop_at, input bit toggle);
    int n;
    bit stopped;
    stopped = 0;
    candyflag = 1'b0;
    repeat (3) tick();
    sel = s[SEL_W-1:0]; amount = a[AMT_W-1:0]; mode = md[1:0];
    busy_cyc = 0; rises = 0;
    candyflag = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!(busy || done) && n < 10);
    chk("req_latency", 32'(n), 32'd3);
    for (int i = 0; i < 400 && phase == 1; i++) begin
      if (stop && phase == 1) stopped = 1;
      stop = 1'b0;
      if (phase == 1 && k == stop_at) stop = 1'b1;
      if (toggle && phase == 1 && k == 7) candyflag = 1'b0;
      if (toggle && phase == 1 && k == 8) candyflag = 1'b1;
      tick();
    end
    if (stop) stopped = 1;
    stop = 1'b0;
    chk("reached_done", 32'(done), 32'd1);
    if (!stopped) begin
      chk("busy_cycles", 32'(busy_cyc), (s < NUM_CH) ? 32'(run_len(a, md)) : 32'd0);
      chk("pulses", 32'(rises), (s < NUM_CH) ? 32'((a + 1) * SPU) : 32'd0);
    end
    repeat (2) begin
      stop = 1'($urandom_range(0, 1));
      tick();
    end
    stop = 1'b0;
    candyflag = 1'b0;
    n = 0;
    do begin tick(); n++; end while (done && n < 8);
    chk("done_fall", 32'(n), 32'd3);
  endtask

  initial begin
    model_reset();
    prev_step = 0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_motor", 32'(dcmotor), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (5) tick();

    run_req(0, 0, 0, -1, 0);
    run_req(2, 3, 2, -1, 0);
    run_req(3, 0, 0, -1, 0);
    run_req(1, 2, 1, 12, 0);

    // reset in the middle of a stepping phase
    candyflag = 1'b0;
    repeat (3) tick();
    sel = 3'd1; amount = 2'd1; mode = 2'd0;
    candyflag = 1'b1;
    for (int i = 0; i < 30 && !(phase == 1 && k == 8); i++) tick();
    chk("midrun_in_step", 32'(busy), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_step", 32'(stepper_step), 32'd0);
    chk("async_motor", 32'(dcmotor), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_dir", 32'(stepper_dir), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    model_reset();
    repeat (2) tick();
    rstn = 1'b1;
    repeat (5) tick();
    run_req(1, 1, 0, -1, 1);

    for (int it = 0; it < 25; it++) begin
      int s, a, md, sa;
      s  = $urandom_range(0, 4);
      a  = $urandom_range(0, 3);
      md = $urandom_range(0, 3);
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
      run_req(s, a, md, sa, (sa < 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end
endmodule
